// File: rtl/ff_pkg.sv
`default_nettype none
// ============================================================================
// ff_pkg : shared FSM state encoding and sizing helper for the flip-flop blocks
// Revision 1.0 - initial release
// ============================================================================
package ff_pkg;

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  // Width needed to count 0..filter_cycles inclusive.
  function automatic int qcnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

  localparam int DEFAULT_FILTER_CYCLES = 3;
  localparam int QCNT_W                = qcnt_width(DEFAULT_FILTER_CYCLES);

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// sync_chain : STAGES-deep reset-to-zero synchronizer for one asynchronous bit
// Revision 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/t_decoder.sv
`default_nettype none
// ============================================================================
// t_decoder : glitch-filtered receiver for a toggle-encoded line, one t pulse
//             per accepted change. Optional counter under macro TOGGLE_CNT_EN.
// Revision 1.0 - initial release
// ============================================================================
module t_decoder
  import ff_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  input  logic             cnt_clr,
  output logic             t,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int              QW        = qcnt_width(FILTER_CYCLES);
  localparam logic [QW-1:0]   QCNT_LAST = QW'(FILTER_CYCLES - 1);

  logic          sync_lvl;
  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          out_q, out_d;
  logic          t_q, t_d;
  logic          busy_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (toggle_in),
    .q   (sync_lvl)
  );

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    out_d   = out_q;
    t_d     = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_lvl != out_q) begin
          // A one-cycle filter has nothing to qualify: accept immediately.
          if (FILTER_CYCLES == 1) begin
            out_d = ~out_q;
            t_d   = 1'b1;
          end else begin
            qcnt_d  = QW'(1);
            state_d = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        if (sync_lvl == out_q) begin
          qcnt_d  = '0;
          state_d = ST_STABLE;
        end else if (qcnt_q == QCNT_LAST) begin
          out_d   = ~out_q;
          t_d     = 1'b1;
          qcnt_d  = '0;
          state_d = ST_STABLE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STABLE;
      qcnt_q  <= '0;
      out_q   <= 1'b0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      out_q   <= out_d;
      t_q     <= t_d;
      busy_q  <= (state_d == ST_QUALIFY);
    end
  end

  assign t    = t_q;
  assign out  = out_q;
  assign busy = busy_q;

`ifdef TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over a coincident t pulse; count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                   cnt_d = '0;
    else if (t_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign toggle_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_t_decoder.sv
`default_nettype none
// ============================================================================
// tb_t_decoder : directed + random stimulus checked against a run-length model
// Revision 1.0 - initial release
// ============================================================================
module tb_t_decoder;

  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 3;
`ifdef TOGGLE_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             toggle_in;
  logic             cnt_clr;
  logic             t;
  logic             out;
  logic             busy;
  logic [CNT_W-1:0] toggle_cnt;

  always #5 clk = ~clk;

  t_decoder #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .toggle_in  (toggle_in),
    .cnt_clr    (cnt_clr),
    .t          (t),
    .out        (out),
    .busy       (busy),
    .toggle_cnt (toggle_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulses;
  int busy_cycles;
  int pulse_q[$];

  // Reference model: a delay line of SYNC_STAGES samples feeding a rule
  // "flip the level once the delayed input has differed from it for
  // FILTER_CYCLES consecutive cycles".
  bit m_pipe[SYNC_STAGES];
  bit m_out;
  bit m_t;
  int m_run;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 1'b0;
    m_out = 1'b0;
    m_t   = 1'b0;
    m_run = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit tin, input bit clr);
    bit s;
    s = m_pipe[SYNC_STAGES-1];
`ifdef TOGGLE_CNT_EN
    if (clr) m_cnt = 0;
    else if (m_t && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
    m_t = 1'b0;
    if (s != m_out) begin
      m_run++;
      if (m_run == FILTER_CYCLES) begin
        m_out = ~m_out;
        m_t   = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = tin;
  endtask

  // Called at a negedge: drive inputs, advance one clock, compare at next negedge.
  task automatic cycle(input bit tin, input bit clr);
    toggle_in = tin;
    cnt_clr   = clr;
    model_step(tin, clr);
    cyc++;
    @(posedge clk);
    @(negedge clk);
    chk("t",    {31'd0, t},    {31'd0, m_t});
    chk("out",  {31'd0, out},  {31'd0, m_out});
    chk("busy", {31'd0, busy}, {31'd0, (m_run != 0)});
    chk("cnt",  32'(toggle_cnt), 32'(m_cnt));
    if (t === 1'b1) begin
      pulses++;
      pulse_q.push_back(cyc);
    end
    if (busy === 1'b1) busy_cycles++;
  endtask

  // Drive a level and report how many edges after the change t first rose.
  task automatic wait_pulse(input bit tin, output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(tin, 1'b0);
      if (t === 1'b1 && lat < 0) lat = i - 1;
    end
  endtask

  // Assert reset away from any clock edge, check outputs clear at once.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_t",    {31'd0, t},    32'd0);
    chk("rst_out",  {31'd0, out},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt",  32'(toggle_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    bit lvl;
    rst       = 1'b1;
    toggle_in = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_out", {31'd0, out}, 32'd0);
    rst = 1'b0;

    // Quiet line: nothing happens.
    pulses = 0;
    repeat (20) cycle(1'b0, 1'b0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Single rising change: latency 4, out follows.
    wait_pulse(1'b1, lat);
    chk("step_lat", 32'(lat), 32'd4);
    chk("step_out", {31'd0, out}, 32'd1);

    // Two-cycle low glitch is rejected.
    pulses = 0; busy_cycles = 0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_busy",   32'(busy_cycles), 32'd2);

    // Five changes six cycles apart.
    pulses = 0;
    pulse_q.delete();
    for (int k = 0; k < 5; k++) repeat (6) cycle(k[0], 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    chk("train_pulses", 32'(pulses), 32'd5);
    for (int i = 1; i < pulse_q.size(); i++)
      chk("train_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'd6);

    // Reset mid-qualification with toggle_in high.
    repeat (3) cycle(1'b1, 1'b0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    async_reset();
    wait_pulse(1'b1, lat);
    chk("rst_lat", 32'(lat), 32'd4);
    chk("rst_out_after", {31'd0, out}, 32'd1);

    // Four more toggles: counter saturates when enabled.
    for (int k = 0; k < 4; k++) repeat (6) cycle(k[0], 1'b0);
    repeat (4) cycle(1'b1, 1'b0);
`ifdef TOGGLE_CNT_EN
    chk("cnt_sat", 32'(toggle_cnt), 32'd3);
`else
    chk("cnt_sat", 32'(toggle_cnt), 32'd0);
`endif

    // Clear coinciding with the t pulse.
    for (int i = 0; i < 8; i++) cycle(1'b0, m_t);
    chk("cnt_clr_t", 32'(toggle_cnt), 32'd0);

    // Random segments of held levels, occasional clear and reset.
    lvl = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      int hold;
      hold = $urandom_range(1, 8);
      lvl  = ~lvl;
      for (int i = 0; i < hold; i++) cycle(lvl, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
